// File: rtl/bgr_startup_ctrl.sv
// Start-up sequencer for the bandgap core: pulses porst to kick the loop out of its zero-current
// state, qualifies vbg_ok, re-kicks on timeout or loss of regulation, and reports ready/fault.
module bgr_startup_ctrl #(
  parameter int unsigned PULSE_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned OK_FILTER     = 8,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16,
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vbg_ok,
  output logic          porst,
  output logic          ready,
  output logic          fault,
  output logic          lock_lost,
  output logic [RW-1:0] retry_cnt,
  output logic [2:0]    state
);

  localparam int unsigned FW = $clog2(OK_FILTER + 1);

  localparam logic [CNT_W-1:0] PulseLast  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [FW-1:0]    FilterMax  = FW'(OK_FILTER);
  localparam logic [RW-1:0]    RetryMax   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StKick   = 3'd1,
    StSettle = 3'd2,
    StReady  = 3'd3,
    StFault  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [FW-1:0]    f_cnt_q, f_cnt_d, f_inc;
  logic [RW-1:0]    retry_q, retry_d;
  logic             sync_q, ok_s;
  logic             lost_d;

  assign f_inc = (f_cnt_q == FilterMax) ? FilterMax : f_cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    f_cnt_d = '0;
    retry_d = retry_q;
    lost_d  = 1'b0;
    if (!en) begin
      state_d = StIdle;
      timer_d = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StKick;
          timer_d = '0;
          retry_d = '0;
        end
        StKick: begin
          if (timer_q == PulseLast) begin
            state_d = StSettle;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StSettle: begin
          f_cnt_d = ok_s ? f_inc : '0;
          timer_d = timer_q + 1'b1;
          // A qualified good vbg wins over a coincident timeout.
          if (f_cnt_d == FilterMax) begin
            state_d = StReady;
            f_cnt_d = '0;
            timer_d = '0;
          end else if (timer_q == SettleLast) begin
            f_cnt_d = '0;
            timer_d = '0;
            if (retry_q < RetryMax) begin
              state_d = StKick;
              retry_d = retry_q + 1'b1;
            end else begin
              state_d = StFault;
            end
          end
        end
        StReady: begin
          f_cnt_d = ok_s ? '0 : f_inc;
          if (f_cnt_d == FilterMax) begin
            state_d = StKick;
            f_cnt_d = '0;
            timer_d = '0;
            retry_d = '0;
            lost_d  = 1'b1;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      f_cnt_q   <= '0;
      retry_q   <= '0;
      sync_q    <= 1'b0;
      ok_s      <= 1'b0;
      porst     <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      f_cnt_q   <= f_cnt_d;
      retry_q   <= retry_d;
      sync_q    <= vbg_ok;
      ok_s      <= sync_q;
      porst     <= (state_d == StKick);
      ready     <= (state_d == StReady);
      fault     <= (state_d == StFault);
      lock_lost <= lost_d;
    end
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Bench for bgr_startup_ctrl: directed bring-up scenarios plus random stimulus, all checked
// every cycle against a behavioural model of the sequencer.
module tb_bgr_startup_ctrl;

  localparam int P  = 16;
  localparam int S  = 1024;
  localparam int F  = 8;
  localparam int MR = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          vbg_ok = 1'b0;
  logic          porst, ready, fault, lock_lost;
  logic [RW-1:0] retry_cnt;
  logic [2:0]    state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  bgr_startup_ctrl #(
    .PULSE_CYCLES (P),
    .SETTLE_CYCLES(S),
    .OK_FILTER    (F),
    .MAX_RETRY    (MR),
    .CNT_W        (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .vbg_ok   (vbg_ok),
    .porst    (porst),
    .ready    (ready),
    .fault    (fault),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase uses the debug codes 0 idle, 1 kick, 2 settle, 3 ready, 4 fault.
  int       m_phase = 0;
  int       m_kick_left = 0;
  int       m_settle_used = 0;
  int       m_retry = 0;
  int       m_run = 0;
  bit       m_lost = 1'b0;
  bit [1:0] m_sync = 2'b00;

  always @(posedge clk) begin
    bit m_ok;
    m_ok   = m_sync[1];
    m_sync = {m_sync[0], vbg_ok};
    m_lost = 1'b0;
    if (rst) begin
      m_phase = 0; m_retry = 0; m_run = 0; m_sync = 2'b00;
    end else if (!en) begin
      m_phase = 0; m_retry = 0; m_run = 0;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_kick_left = P; m_retry = 0; end
        1: begin
          m_kick_left--;
          if (m_kick_left == 0) begin m_phase = 2; m_settle_used = 0; m_run = 0; end
        end
        2: begin
          m_settle_used++;
          m_run = m_ok ? m_run + 1 : 0;
          if (m_run >= F) begin
            m_phase = 3; m_run = 0;
          end else if (m_settle_used == S) begin
            m_run = 0;
            if (m_retry < MR) begin m_retry++; m_phase = 1; m_kick_left = P; end
            else m_phase = 4;
          end
        end
        3: begin
          m_run = m_ok ? 0 : m_run + 1;
          if (m_run >= F) begin
            m_phase = 1; m_kick_left = P; m_retry = 0; m_lost = 1'b1; m_run = 0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("state", int'(state), m_phase);
      check("porst", int'(porst), int'(m_phase == 1));
      check("ready", int'(ready), int'(m_phase == 3));
      check("fault", int'(fault), int'(m_phase == 4));
      check("lock_lost", int'(lock_lost), int'(m_lost));
      check("retry_cnt", int'(retry_cnt), m_retry);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  int  cnt_a, cnt_b, first_j, seq;
  bit  prev, found;
  int  len;
  bit  rv, re, rr;

  task automatic go_idle();
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_porst", int'(porst), 0);
    check("rst_retry", int'(retry_cnt), 0);

    // Scenario 1: vbg_ok stable high
    rst = 1'b0; vbg_ok = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b1;
    cnt_a = 0; first_j = -1; cnt_b = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (porst) cnt_a++;
      if (ready && first_j < 0) first_j = j + 1;
      if (fault) cnt_b++;
    end
    check("s1_porst_len", cnt_a, 16);
    check("s1_ready_t", first_j, 25);
    check("s1_retry", int'(retry_cnt), 0);
    check("s1_fault_cnt", cnt_b, 0);

    // Scenario 3: short glitch ignored, sustained loss re-kicks
    vbg_ok = 1'b0;
    repeat (5) @(negedge clk);
    vbg_ok = 1'b1;
    cnt_a = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (!ready || lock_lost) cnt_a++;
    end
    check("s3_glitch", cnt_a, 0);
    vbg_ok = 1'b0; cnt_a = 0; cnt_b = 0;
    for (int j = 0; j < 90; j++) begin
      if (j == 20) vbg_ok = 1'b1;
      @(negedge clk);
      if (lock_lost) cnt_a++;
      if (porst) cnt_b++;
    end
    check("s3_lost_pulses", cnt_a, 1);
    check("s3_porst_len", cnt_b, 16);
    check("s3_ready_again", int'(ready), 1);
    check("s3_retry", int'(retry_cnt), 0);

    // Scenario 4: en dropped in the 5th kick cycle
    vbg_ok = 1'b0;
    go_idle();
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("s4_kick_on", int'(porst), 1);
    en = 1'b0;
    @(negedge clk);
    check("s4_abort_state", int'(state), 0);
    check("s4_abort_porst", int'(porst), 0);
    en = 1'b1; cnt_a = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (porst) cnt_a++;
    end
    check("s4_fresh_kick", cnt_a, 16);

    // Scenario 5: reset in SETTLE with retry_cnt=2
    go_idle();
    en = 1'b1; found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (state == 3'd2 && retry_cnt == 2'd2) found = 1'b1;
    end
    check("s5_reach", int'(found), 1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("s5_state", int'(state), 0);
    check("s5_outs", int'({porst, ready, fault, lock_lost, retry_cnt}), 0);
    rst = 1'b0;

    // Scenario 2: vbg_ok stuck low, all retries exhausted
    go_idle();
    en = 1'b1; cnt_a = 0; seq = 0; prev = 1'b0; first_j = -1;
    for (int j = 0; j < 4400; j++) begin
      @(negedge clk);
      if (porst && !prev) begin cnt_a++; seq = seq * 10 + int'(retry_cnt); end
      prev = porst;
      if (fault && first_j < 0) first_j = j;
    end
    check("s2_pulses", cnt_a, 4);
    check("s2_retry_seq", seq, 123);
    check("s2_fault_t", first_j, 4160);
    check("s2_porst_off", int'(porst), 0);

    // Scenario 6: vbg_ok toggling every cycle never qualifies
    go_idle();
    en = 1'b1; cnt_a = 0; first_j = -1;
    for (int j = 0; j < 4300; j++) begin
      vbg_ok = ~vbg_ok;
      @(negedge clk);
      if (ready) cnt_a++;
      if (fault && first_j < 0) first_j = j;
    end
    check("s6_ready_cnt", cnt_a, 0);
    check("s6_fault_t", first_j, 4160);

    // Random bursts of vbg_ok, en drops and occasional resets
    for (int k = 0; k < 80; k++) begin
      len = $urandom_range(1, 120);
      rv  = 1'($urandom_range(0, 1));
      re  = ($urandom_range(0, 9) != 0);
      rr  = ($urandom_range(0, 29) == 0);
      en = re; rst = rr; vbg_ok = rv;
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        rst = 1'b0;
        if ($urandom_range(0, 19) == 0) vbg_ok = ~vbg_ok;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
